sample_frame_collector: RTL and testbench

SAMPLE_FRAME_COLLECTOR -- requirements
Module: sample_frame_collector

---
 rtl/rf_pkg.sv | 19 +
 rtl/feat_pingpong_ram.sv | 42 ++++
 rtl/sample_frame_collector.sv | 210 +++++++++++++++++++++
 tb/tb_sample_frame_collector.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the sample frame collector: controller states and
// the read latency of the upstream sample FIFO.
package rf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRST      = 3'd1,
    ST_FETCH     = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_WAIT_BANK = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam int RD_LAT = 4;

  // Wide enough to count every pop that can be in flight, plus headroom.
  localparam int INFL_W = $clog2(RD_LAT + 1) + 1;

endpackage

// File: rtl/feat_pingpong_ram.sv
// Two-bank feature store: one write port and one registered read port.
// The read port returns zero when the caller flags the address as out of range.
module feat_pingpong_ram #(
  parameter int WIDTH    = 16,
  parameter int FEAT_BIT = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic                wbank_i,
  input  logic [FEAT_BIT-1:0] waddr_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic                rbank_i,
  input  logic [FEAT_BIT-1:0] raddr_i,
  input  logic                rzero_i,
  output logic [WIDTH-1:0]    rdata_o
);

  localparam int ENTRIES = 2 ** (FEAT_BIT + 1);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{wbank_i, waddr_i}] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rzero_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[{rbank_i, raddr_i}];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_frame_collector.sv
// Pops feature words from an upstream FIFO, assembles them into samples in a
// ping-pong store, and hands complete samples to a consumer one at a time.
module sample_frame_collector
  import rf_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FEAT_BIT  = 5,
  parameter int DEPTH_BIT = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [FEAT_BIT-1:0]  i_num_feat,
  output logic                 o_ptr_rst,
  output logic                 o_pop,
  input  logic                 i_is_empty,
  input  logic [WIDTH-1:0]     i_front,
  input  logic                 i_vld,
  output logic                 o_smp_vld,
  input  logic                 i_smp_rdy,
  input  logic [FEAT_BIT-1:0]  i_feat_raddr,
  output logic [WIDTH-1:0]     o_feat_rdata,
  output logic [DEPTH_BIT-1:0] o_smp_cnt,
  output logic                 o_done,
  output logic                 o_err
);

  state_e               state_q, state_d;
  logic [FEAT_BIT-1:0]  num_feat_q, num_feat_d;
  logic [FEAT_BIT-1:0]  pop_cnt_q, pop_cnt_d;
  logic [FEAT_BIT-1:0]  wr_idx_q, wr_idx_d;
  logic [INFL_W-1:0]    inflight_q, inflight_d;
  logic [1:0]           full_q, full_d;
  logic                 wbank_q, wbank_d;
  logic                 rbank_q, rbank_d;
  logic [DEPTH_BIT-1:0] smp_cnt_q, smp_cnt_d;
  logic                 err_q, err_d;
  logic                 end_q, end_d;
  logic                 part_q, part_d;

  logic pop_acc;
  logic wr_en;
  logic last_wr;
  logic smp_rel;
  logic rd_zero;

  assign o_pop   = (state_q == ST_FETCH);
  assign pop_acc = o_pop & ~i_is_empty;

  // Only words we actually asked for are stored; anything arriving with no
  // pop outstanding (e.g. leftovers from before a reset) is dropped.
  assign wr_en   = i_vld & (inflight_q != '0);
  assign last_wr = wr_en & (wr_idx_q == num_feat_q);
  assign smp_rel = full_q[rbank_q] & i_smp_rdy;
  assign rd_zero = (i_feat_raddr > num_feat_q);

  always_comb begin
    state_d    = state_q;
    num_feat_d = num_feat_q;
    pop_cnt_d  = pop_cnt_q;
    wr_idx_d   = wr_idx_q;
    full_d     = full_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    smp_cnt_d  = smp_cnt_q;
    err_d      = err_q;
    end_d      = end_q;
    part_d     = part_q;
    inflight_d = inflight_q + INFL_W'(pop_acc) - INFL_W'(wr_en);

    if (wr_en) begin
      wr_idx_d = last_wr ? '0 : wr_idx_q + 1'b1;
      if (last_wr) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end

    // Fill and release always target different banks, so both can apply.
    if (smp_rel) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
      smp_cnt_d       = smp_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          num_feat_d = i_num_feat;
          pop_cnt_d  = '0;
          wr_idx_d   = '0;
          inflight_d = '0;
          full_d     = '0;
          wbank_d    = 1'b0;
          rbank_d    = 1'b0;
          smp_cnt_d  = '0;
          err_d      = 1'b0;
          end_d      = 1'b0;
          part_d     = 1'b0;
          state_d    = ST_PRST;
        end
      end
      ST_PRST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (pop_acc) begin
          if (pop_cnt_q == num_feat_q) begin
            pop_cnt_d = '0;
            state_d   = ST_DRAIN;
          end else begin
            pop_cnt_d = pop_cnt_q + 1'b1;
          end
        end else if (i_is_empty) begin
          pop_cnt_d = '0;
          if (pop_cnt_q != '0) begin
            part_d  = 1'b1;
            state_d = ST_DRAIN;
          end else if ((full_q == 2'b00) && (inflight_q == '0)) begin
            state_d = ST_DONE;
          end else begin
            end_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Every decision here waits until all requested words have landed.
        if (inflight_q == '0) begin
          if (part_q) begin
            part_d   = 1'b0;
            wr_idx_d = '0;
            err_d    = 1'b1;
            state_d  = ST_DONE;
          end else if (end_q) begin
            if (full_q == 2'b00) begin
              end_d   = 1'b0;
              state_d = ST_DONE;
            end
          end else if (full_q[wbank_q]) begin
            state_d = ST_WAIT_BANK;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_WAIT_BANK: begin
        if (!full_q[wbank_q]) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      num_feat_q <= '0;
      pop_cnt_q  <= '0;
      wr_idx_q   <= '0;
      inflight_q <= '0;
      full_q     <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      smp_cnt_q  <= '0;
      err_q      <= 1'b0;
      end_q      <= 1'b0;
      part_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_feat_q <= num_feat_d;
      pop_cnt_q  <= pop_cnt_d;
      wr_idx_q   <= wr_idx_d;
      inflight_q <= inflight_d;
      full_q     <= full_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      smp_cnt_q  <= smp_cnt_d;
      err_q      <= err_d;
      end_q      <= end_d;
      part_q     <= part_d;
    end
  end

  feat_pingpong_ram #(
    .WIDTH    (WIDTH),
    .FEAT_BIT (FEAT_BIT)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en),
    .wbank_i (wbank_q),
    .waddr_i (wr_idx_q),
    .wdata_i (i_front),
    .rbank_i (rbank_q),
    .raddr_i (i_feat_raddr),
    .rzero_i (rd_zero),
    .rdata_o (o_feat_rdata)
  );

  assign o_ptr_rst = (state_q == ST_PRST);
  assign o_done    = (state_q == ST_DONE);
  assign o_err     = err_q;
  assign o_smp_vld = full_q[rbank_q];
  assign o_smp_cnt = smp_cnt_q;

endmodule

// File: tb/tb_sample_frame_collector.sv
// Bench for sample_frame_collector: an upstream FIFO model with a fixed
// four-cycle read latency, a consumer, and a chunking reference model.
`timescale 1ns/1ps
module tb_sample_frame_collector;

  localparam int WIDTH     = 16;
  localparam int FEAT_BIT  = 5;
  localparam int DEPTH_BIT = 13;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 i_start = 1'b0;
  logic [FEAT_BIT-1:0]  i_num_feat = '0;
  logic                 o_ptr_rst;
  logic                 o_pop;
  logic                 i_is_empty = 1'b1;
  logic [WIDTH-1:0]     i_front = '0;
  logic                 i_vld = 1'b0;
  logic                 o_smp_vld;
  logic                 i_smp_rdy = 1'b0;
  logic [FEAT_BIT-1:0]  i_feat_raddr = '0;
  logic [WIDTH-1:0]     o_feat_rdata;
  logic [DEPTH_BIT-1:0] o_smp_cnt;
  logic                 o_done;
  logic                 o_err;

  sample_frame_collector #(
    .WIDTH     (WIDTH),
    .FEAT_BIT  (FEAT_BIT),
    .DEPTH_BIT (DEPTH_BIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_num_feat   (i_num_feat),
    .o_ptr_rst    (o_ptr_rst),
    .o_pop        (o_pop),
    .i_is_empty   (i_is_empty),
    .i_front      (i_front),
    .i_vld        (i_vld),
    .o_smp_vld    (o_smp_vld),
    .i_smp_rdy    (i_smp_rdy),
    .i_feat_raddr (i_feat_raddr),
    .o_feat_rdata (o_feat_rdata),
    .o_smp_cnt    (o_smp_cnt),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int               due;
    logic [WIDTH-1:0] d;
  } pend_t;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] obs_q[$];
  logic [WIDTH-1:0] oor_q[$];
  pend_t            pipe_q[$];
  int               ncyc = 0;
  int               pops_acc = 0;
  bit               acc_pend = 1'b0;
  bit               timed_out = 1'b0;

  // Upstream FIFO: a pop accepted at a rising edge returns its word with
  // i_vld at the fourth rising edge after it. Inputs change on falling edges.
  always @(negedge clk) begin
    pend_t p;
    ncyc++;
    if (acc_pend && fifo_q.size() > 0) begin
      p.due = ncyc + 3;
      p.d   = fifo_q.pop_front();
      pipe_q.push_back(p);
      pops_acc++;
    end
    i_is_empty = (fifo_q.size() == 0);
    if (pipe_q.size() > 0 && pipe_q[0].due == ncyc) begin
      i_vld   = 1'b1;
      i_front = pipe_q[0].d;
      void'(pipe_q.pop_front());
    end else begin
      i_vld   = 1'b0;
      i_front = WIDTH'($urandom);
    end
    acc_pend = o_pop && !i_is_empty;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_rand(input int n);
    logic [WIDTH-1:0] w;
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      w = WIDTH'($urandom);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    pops_acc = 0;
    @(negedge clk); #1;
  endtask

  task automatic start_batch(input int nf);
    i_start    = 1'b1;
    i_num_feat = FEAT_BIT'(nf);
    @(negedge clk); #1;
    i_start    = 1'b0;
  endtask

  // Consumer: reads every feature of each offered sample (plus one address
  // past the end), then releases it; stops once the batch reports done.
  task automatic collect(input int nf, input int max_hold);
    int cyc;
    int hold;
    bit fin;
    cyc = 0;
    fin = 1'b0;
    timed_out = 1'b0;
    obs_q.delete();
    oor_q.delete();
    while (!fin) begin
      if (cyc > 3000) begin
        timed_out = 1'b1;
        fin = 1'b1;
      end else begin
        @(negedge clk); #1;
        cyc++;
        if (o_smp_vld) begin
          hold = $urandom_range(max_hold, 0);
          repeat (hold) begin @(negedge clk); #1; end
          for (int a = 0; a <= nf; a++) begin
            i_feat_raddr = FEAT_BIT'(a);
            @(negedge clk); #1;
            obs_q.push_back(o_feat_rdata);
          end
          if (nf < 31) begin
            i_feat_raddr = FEAT_BIT'(nf + 1);
            @(negedge clk); #1;
            oor_q.push_back(o_feat_rdata);
          end
          i_smp_rdy = 1'b1;
          @(negedge clk); #1;
          i_smp_rdy = 1'b0;
          cyc += nf + 4 + hold;
        end else if (o_done) begin
          fin = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (o_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %0b want 0", o_pop); end
    checks++; if (o_ptr_rst !== 1'b0) begin errors++; $display("FAIL reset_ptr_rst: got %0b want 0", o_ptr_rst); end
    checks++; if (o_smp_vld !== 1'b0) begin errors++; $display("FAIL reset_smp_vld: got %0b want 0", o_smp_vld); end
    checks++; if (o_feat_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %0h want 0", o_feat_rdata); end
    checks++; if (o_smp_cnt !== '0) begin errors++; $display("FAIL reset_smp_cnt: got %0d want 0", o_smp_cnt); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", o_done); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", o_err); end
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] w;
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      w = WIDTH'(10 + i);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    pops_acc = 0;
    @(negedge clk); #1;
    start_batch(3);
    checks++; if (o_ptr_rst !== 1'b1) begin errors++; $display("FAIL single_ptr_rst_hi: got %0b want 1", o_ptr_rst); end
    @(negedge clk); #1;
    checks++; if (o_ptr_rst !== 1'b0) begin errors++; $display("FAIL single_ptr_rst_lo: got %0b want 0", o_ptr_rst); end
    collect(3, 0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL single_timeout: batch did not finish"); end
    checks++;
    if (obs_q.size() != 4) begin
      errors++; $display("FAIL single_nwords: got %0d want 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_word%0d: got %0h want %0h", i, obs_q[i], exp_q[i]); end
      end
    end
    checks++; if (oor_q.size() != 1 || oor_q[0] !== '0) begin errors++; $display("FAIL single_oor: out-of-range read not zero (n=%0d)", oor_q.size()); end
    checks++; if (o_smp_cnt !== 13'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", o_smp_cnt); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL single_done: got %0b want 1", o_done); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL single_err: got %0b want 0", o_err); end
    checks++; if (pops_acc != 4) begin errors++; $display("FAIL single_pops: got %0d want 4", pops_acc); end
  endtask

  task automatic test_backpressure();
    load_rand(6);
    start_batch(1);
    repeat (40) @(negedge clk);
    #1;
    checks++; if (o_pop !== 1'b0) begin errors++; $display("FAIL bp_pop: got %0b want 0", o_pop); end
    checks++; if (pops_acc != 4) begin errors++; $display("FAIL bp_pops: got %0d want 4", pops_acc); end
    checks++; if (o_smp_vld !== 1'b1) begin errors++; $display("FAIL bp_smp_vld: got %0b want 1", o_smp_vld); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL bp_done_early: got %0b want 0", o_done); end
    collect(1, 2);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL bp_timeout: batch did not finish"); end
    checks++;
    if (obs_q.size() != 6) begin
      errors++; $display("FAIL bp_nwords: got %0d want 6", obs_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d: got %0h want %0h", i, obs_q[i], exp_q[i]); end
      end
    end
    checks++; if (o_smp_cnt !== 13'd3) begin errors++; $display("FAIL bp_cnt: got %0d want 3", o_smp_cnt); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL bp_err: got %0b want 0", o_err); end
  endtask

  task automatic test_partial();
    load_rand(5);
    start_batch(2);
    collect(2, 1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL part_timeout: batch did not finish"); end
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL part_nwords: got %0d want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL part_word%0d: got %0h want %0h", i, obs_q[i], exp_q[i]); end
      end
    end
    checks++; if (o_smp_cnt !== 13'd1) begin errors++; $display("FAIL part_cnt: got %0d want 1", o_smp_cnt); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL part_err: got %0b want 1", o_err); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL part_done: got %0b want 1", o_done); end
    checks++; if (pops_acc != 5) begin errors++; $display("FAIL part_pops: got %0d want 5", pops_acc); end
  endtask

  task automatic test_empty();
    bit seen;
    load_rand(0);
    start_batch(2);
    seen = 1'b0;
    for (int k = 0; k < 3 && !seen; k++) begin
      @(negedge clk); #1;
      if (o_done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL empty_done: got done=%0b within 3 cycles, want 1", o_done); end
    checks++; if (pops_acc != 0) begin errors++; $display("FAIL empty_pops: got %0d want 0", pops_acc); end
    checks++; if (o_smp_cnt !== '0) begin errors++; $display("FAIL empty_cnt: got %0d want 0", o_smp_cnt); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL empty_err: got %0b want 0", o_err); end
  endtask

  task automatic test_reset_mid();
    bit found;
    load_rand(8);
    start_batch(3);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk); #1;
      if (pops_acc == 4 && pipe_q.size() == 2 && !o_pop) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstmid_window: drain with 2 pending words not seen (pops=%0d)", pops_acc); end
    rst = 1'b1;
    #1;
    checks++;
    if ({o_pop, o_ptr_rst, o_smp_vld, o_done, o_err, o_smp_cnt, o_feat_rdata} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got pop=%0b prst=%0b vld=%0b done=%0b err=%0b cnt=%0d rdata=%0h want all 0",
               o_pop, o_ptr_rst, o_smp_vld, o_done, o_err, o_smp_cnt, o_feat_rdata);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checks++; if (o_smp_vld !== 1'b0) begin errors++; $display("FAIL rstmid_stale_vld: got %0b want 0", o_smp_vld); end
    checks++; if (o_smp_cnt !== '0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", o_smp_cnt); end
    load_rand(8);
    start_batch(3);
    collect(3, 1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rstmid_timeout: batch did not finish"); end
    checks++;
    if (obs_q.size() != 8) begin
      errors++; $display("FAIL rstmid_nwords: got %0d want 8", obs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_word%0d: got %0h want %0h", i, obs_q[i], exp_q[i]); end
      end
    end
    checks++; if (o_smp_cnt !== 13'd2) begin errors++; $display("FAIL rstmid_after_cnt: got %0d want 2", o_smp_cnt); end
    checks++; if (o_err !== 1'b0 || o_done !== 1'b1) begin errors++; $display("FAIL rstmid_after_flags: got err=%0b done=%0b want 0/1", o_err, o_done); end
  endtask

  task automatic test_random();
    int nf;
    int n;
    int nsmp;
    bit exp_err;
    for (int it = 0; it < 6; it++) begin
      nf = $urandom_range(4, 0);
      n  = $urandom_range(14, 0);
      nsmp    = n / (nf + 1);
      exp_err = (n % (nf + 1)) != 0;
      load_rand(n);
      start_batch(nf);
      collect(nf, 3);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout: nf=%0d n=%0d", it, nf, n); end
      checks++;
      if (obs_q.size() != nsmp * (nf + 1)) begin
        errors++; $display("FAIL rand%0d_nwords: got %0d want %0d", it, obs_q.size(), nsmp * (nf + 1));
      end else begin
        for (int i = 0; i < obs_q.size(); i++) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word%0d: got %0h want %0h", it, i, obs_q[i], exp_q[i]); end
        end
      end
      for (int i = 0; i < oor_q.size(); i++) begin
        checks++;
        if (oor_q[i] !== '0) begin errors++; $display("FAIL rand%0d_oor%0d: got %0h want 0", it, i, oor_q[i]); end
      end
      checks++; if (o_smp_cnt !== DEPTH_BIT'(nsmp)) begin errors++; $display("FAIL rand%0d_cnt: got %0d want %0d", it, o_smp_cnt, nsmp); end
      checks++; if (o_err !== exp_err) begin errors++; $display("FAIL rand%0d_err: got %0b want %0b", it, o_err, exp_err); end
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL rand%0d_done: got %0b want 1", it, o_done); end
      checks++; if (pops_acc != n) begin errors++; $display("FAIL rand%0d_pops: got %0d want %0d", it, pops_acc, n); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_partial();
    test_empty();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
